ps2_keymatrix: RTL and testbench

// - Receives PS/2 keyboard frames and keeps an 8x8 EG2000 key matrix of currently pressed keys.
// - Answers CPU keyboard reads: the row-select lines from the address bus go in, OR-ed column bits come out.
// - Sits directly upstream of the glue keyboard decode and replaces raw ps2 pin handling inside glue.

---
 rtl/ps2_keymatrix_if.sv | 12 +
 rtl/ps2_keymatrix.sv | 199 +++++++++++++++++++
 tb/tb_ps2_keymatrix.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keymatrix_if.sv
// CPU-side view of the PS/2 key matrix: row select goes in, column bits and scancode events come out.
interface ps2_keymatrix_if;
    logic [7:0] row;
    logic [7:0] col;
    logic       strobe;
    logic [7:0] code;
    logic       perr;
    logic       f12;

    modport master (output row, input col, input strobe, input code, input perr, input f12);
    modport slave  (input row, output col, output strobe, output code, output perr, output f12);
endinterface

// File: rtl/ps2_keymatrix.sv
// PS/2 receiver that keeps an 8x8 EG2000 key matrix of held keys and answers CPU row-select reads.
// The ps2 lines are synchronised, the clock line glitch-filtered, and frames decoded on filtered falling edges.
module ps2_keymatrix #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 35468
) (
    input  logic           clock,
    input  logic           power,
    input  logic [1:0]     ps2_i,
    ps2_keymatrix_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]        sync1_q, sync2_q;
    logic [FILTER-1:0] filtSh_q;
    logic              filt_q, filt_d;
    logic              fall, edgeSeen, din, timeout;
    logic [TW-1:0]     idle_q, idle_d;
    state_t            state_q, state_d;
    logic [2:0]        bitCnt_q, bitCnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              parOk_q, parOk_d;
    logic              accept, frameErr;
    logic              strobe_q, perr_q;
    logic              ext_q, ext_d, brk_q, brk_d, f12_q, f12_d;
    logic [7:0]        code_q, code_d;
    logic [7:0][7:0]   matrix_q, matrix_d;
    logic [6:0]        key;
    logic [7:0]        colOut;

    // Key table entry is {hit, row, col}; octal literal 7'o1rc reads directly as row r, column c.
    function automatic logic [6:0] keyLookup(input logic ext, input logic [7:0] sc);
        logic [6:0] k;
        k = '0;
        case ({ext, sc})
            9'h00E: k = 7'o100;  9'h01C: k = 7'o101;  9'h032: k = 7'o102;  9'h021: k = 7'o103;
            9'h023: k = 7'o104;  9'h024: k = 7'o105;  9'h02B: k = 7'o106;  9'h034: k = 7'o107;
            9'h033: k = 7'o110;  9'h043: k = 7'o111;  9'h03B: k = 7'o112;  9'h042: k = 7'o113;
            9'h04B: k = 7'o114;  9'h03A: k = 7'o115;  9'h031: k = 7'o116;  9'h044: k = 7'o117;
            9'h04D: k = 7'o120;  9'h015: k = 7'o121;  9'h02D: k = 7'o122;  9'h01B: k = 7'o123;
            9'h02C: k = 7'o124;  9'h03C: k = 7'o125;  9'h02A: k = 7'o126;  9'h01D: k = 7'o127;
            9'h022: k = 7'o130;  9'h035: k = 7'o131;  9'h01A: k = 7'o132;
            9'h045: k = 7'o140;  9'h016: k = 7'o141;  9'h01E: k = 7'o142;  9'h026: k = 7'o143;
            9'h025: k = 7'o144;  9'h02E: k = 7'o145;  9'h036: k = 7'o146;  9'h03D: k = 7'o147;
            9'h03E: k = 7'o150;  9'h046: k = 7'o151;  9'h052: k = 7'o152;  9'h04C: k = 7'o153;
            9'h041: k = 7'o154;  9'h04E: k = 7'o155;  9'h049: k = 7'o156;  9'h04A: k = 7'o157;
            9'h05A: k = 7'o160;  9'h005: k = 7'o161;  9'h076: k = 7'o162;  9'h175: k = 7'o163;
            9'h172: k = 7'o164;  9'h16B: k = 7'o165;  9'h174: k = 7'o166;  9'h029: k = 7'o167;
            9'h012: k = 7'o170;  9'h059: k = 7'o170;  9'h014: k = 7'o174;
            default: k = '0;
        endcase
        return k;
    endfunction

    // The filtered clock only moves once FILTER consecutive samples agree.
    always_comb begin
        filt_d = filt_q;
        if (&filtSh_q) begin
            filt_d = 1'b1;
        end else if (~|filtSh_q) begin
            filt_d = 1'b0;
        end
    end

    assign fall     = filt_q & ~filt_d;
    assign edgeSeen = filt_q ^ filt_d;
    assign din      = sync2_q[1];
    assign timeout  = (idle_q == TW'(TIMEOUT));
    assign idle_d   = edgeSeen ? '0 : (timeout ? idle_q : idle_q + TW'(1));

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            filtSh_q <= '1;
            filt_q   <= 1'b1;
            idle_q   <= '0;
        end else begin
            sync1_q  <= ps2_i;
            sync2_q  <= sync1_q;
            filtSh_q <= {filtSh_q[FILTER-2:0], sync2_q[0]};
            filt_q   <= filt_d;
            idle_q   <= idle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        parOk_d  = parOk_q;
        accept   = 1'b0;
        frameErr = 1'b0;
        if (timeout && state_q != IDLE) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!din) begin
                        state_d  = DATA;
                        bitCnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d  = {din, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 3'd1;
                    if (bitCnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parOk_d = ^{shift_q, din};
                    state_d = STOP;
                end
                STOP: begin
                    if (parOk_q && din) begin
                        accept = 1'b1;
                    end else begin
                        frameErr = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Prefix bytes only arm the flags; any other accepted byte consumes them.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        f12_d    = f12_q;
        code_d   = code_q;
        matrix_d = matrix_q;
        key      = keyLookup(ext_q, shift_q);
        if (accept) begin
            code_d = shift_q;
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (key[6]) begin
                    matrix_d[key[5:3]][key[2:0]] = ~brk_q;
                end
                if (!ext_q && shift_q == 8'h07) begin
                    f12_d = ~brk_q;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            parOk_q  <= 1'b0;
            strobe_q <= 1'b0;
            perr_q   <= 1'b0;
            code_q   <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            f12_q    <= 1'b0;
            matrix_q <= '0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            parOk_q  <= parOk_d;
            strobe_q <= accept;
            perr_q   <= frameErr;
            code_q   <= code_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            f12_q    <= f12_d;
            matrix_q <= matrix_d;
        end
    end

    always_comb begin
        colOut = '0;
        for (int r = 0; r < 8; r++) begin
            if (bus.row[r]) begin
                colOut = colOut | matrix_q[r];
            end
        end
    end

    assign bus.col    = colOut;
    assign bus.strobe = strobe_q;
    assign bus.code   = code_q;
    assign bus.perr   = perr_q;
    assign bus.f12    = f12_q;
endmodule

// File: tb/tb_ps2_keymatrix.sv
// Randomised bench for ps2_keymatrix: frames are generated bit by bit and the outputs compared against
// a key-state model that tracks pressed keys per row/column and the expected scancode stream.
module tb_ps2_keymatrix;
    localparam int FILTER  = 4;
    localparam int TIMEOUT = 300;

    logic       clock = 1'b0;
    logic       power = 1'b1;
    logic [1:0] ps2   = 2'b11;
    int         vectors = 0;
    int         miscompares = 0;
    bit         checkOn = 1'b0;
    bit         randRows = 1'b0;

    bit [7:0]   mMat [8];
    bit         mExt, mBrk, mF12;
    logic [7:0] expCodes [$];
    int         expPerr = 0;
    logic [7:0] popCode;

    // Scancode per key position, 0x100 marks an E0-prefixed code, -1 is an empty slot.
    int keyCode [8][8] = '{
        '{'h00E, 'h01C, 'h032, 'h021, 'h023, 'h024, 'h02B, 'h034},
        '{'h033, 'h043, 'h03B, 'h042, 'h04B, 'h03A, 'h031, 'h044},
        '{'h04D, 'h015, 'h02D, 'h01B, 'h02C, 'h03C, 'h02A, 'h01D},
        '{'h022, 'h035, 'h01A, -1,    -1,    -1,    -1,    -1   },
        '{'h045, 'h016, 'h01E, 'h026, 'h025, 'h02E, 'h036, 'h03D},
        '{'h03E, 'h046, 'h052, 'h04C, 'h041, 'h04E, 'h049, 'h04A},
        '{'h05A, 'h005, 'h076, 'h175, 'h172, 'h16B, 'h174, 'h029},
        '{'h012, -1,    -1,    -1,    'h014, -1,    -1,    -1   }
    };

    ps2_keymatrix_if bus ();

    ps2_keymatrix #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .power (power),
        .ps2_i (ps2),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lookupKey(input bit ext, input logic [7:0] b, output int rr, output int cc);
        int want;
        want = ext ? (256 + int'(b)) : int'(b);
        rr = 0;
        cc = 0;
        if (!ext && b == 8'h59) begin
            rr = 7;
            return 1'b1;
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (keyCode[r][c] == want) begin
                    rr = r;
                    cc = c;
                    return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic void modelByte(input logic [7:0] b);
        int rr, cc;
        if (b == 8'hE0) begin
            mExt = 1'b1;
        end else if (b == 8'hF0) begin
            mBrk = 1'b1;
        end else begin
            if (lookupKey(mExt, b, rr, cc)) mMat[rr][cc] = !mBrk;
            if (!mExt && b == 8'h07) mF12 = !mBrk;
            mExt = 1'b0;
            mBrk = 1'b0;
        end
    endfunction

    function automatic logic [7:0] modelCol(input logic [7:0] rowSel);
        logic [7:0] c;
        c = '0;
        for (int r = 0; r < 8; r++) begin
            if (rowSel[r]) c = c | mMat[r];
        end
        return c;
    endfunction

    function automatic void modelReset();
        for (int r = 0; r < 8; r++) mMat[r] = '0;
        mExt = 1'b0;
        mBrk = 1'b0;
        mF12 = 1'b0;
    endfunction

    // Single compare process: the model advances on each strobe, then all outputs are checked.
    always @(negedge clock) begin
        if (checkOn) begin
            if (bus.strobe === 1'b1) begin
                checkOutput("strobeExpected", 32'(expCodes.size() > 0), 32'd1);
                if (expCodes.size() > 0) begin
                    popCode = expCodes.pop_front();
                    checkOutput("code", 32'(bus.code), 32'(popCode));
                    modelByte(popCode);
                end
            end
            if (bus.perr === 1'b1) begin
                checkOutput("perrExpected", 32'(expPerr > 0), 32'd1);
                if (expPerr > 0) expPerr--;
            end
            checkOutput("col", 32'(bus.col), 32'(modelCol(bus.row)));
            checkOutput("f12", 32'(bus.f12), 32'(mF12));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
            if (randRows) bus.row = 8'($urandom);
        end
    endtask

    task automatic sendBits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2[1] = bits[i];
            tick(4);
            ps2[0] = 1'b0;
            tick(8);
            ps2[0] = 1'b1;
            tick(4);
        end
        ps2[1] = 1'b1;
    endtask

    // kind: 0 good frame, 1 wrong parity, 2 stop bit low.
    task automatic applyStimulus(input logic [7:0] b, input int kind);
        logic [10:0] bits;
        logic        par;
        par = ~^b;
        if (kind == 1) par = ~par;
        bits = {(kind == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
        if (kind == 0) expCodes.push_back(b);
        else expPerr++;
        sendBits(bits, 11);
        tick(4);
        checkOutput("frameDrained", 32'(expCodes.size()), 32'd0);
        checkOutput("perrDrained", 32'(expPerr), 32'd0);
    endtask

    task automatic readCol(input logic [7:0] rowSel, input logic [7:0] exp, input string name);
        bus.row = rowSel;
        tick(1);
        checkOutput(name, 32'(bus.col), 32'(exp));
    endtask

    task automatic glitch(input int len);
        ps2[1] = 1'b0;
        ps2[0] = 1'b0;
        tick(len);
        ps2[0] = 1'b1;
        ps2[1] = 1'b1;
        tick(10);
    endtask

    initial begin
        int kind, r, c;
        logic [7:0] b;
        modelReset();
        bus.row = 8'hFF;
        #3 power = 1'b0;
        checkOn = 1'b1;
        tick(5);
        checkOutput("rstCol", 32'(bus.col), 32'h00);
        checkOutput("rstStrobe", 32'(bus.strobe), 32'd0);
        checkOutput("rstF12", 32'(bus.f12), 32'd0);
        checkOutput("rstPerr", 32'(bus.perr), 32'd0);
        checkOutput("rstCode", 32'(bus.code), 32'h00);
        power = 1'b1;
        tick(20);
        checkOutput("idleCol", 32'(bus.col), 32'h00);
        checkOutput("idleStrobe", 32'(bus.strobe), 32'd0);

        applyStimulus(8'h1C, 0);
        readCol(8'h01, 8'h02, "makeA");
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h1C, 0);
        readCol(8'h01, 8'h00, "breakA");

        applyStimulus(8'h29, 0);
        applyStimulus(8'h12, 0);
        readCol(8'hC0, 8'h81, "rowsC0");
        readCol(8'h40, 8'h80, "row40");
        readCol(8'h80, 8'h01, "row80");
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h29, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h12, 0);

        applyStimulus(8'hE0, 0);
        applyStimulus(8'h75, 0);
        readCol(8'h40, 8'h08, "extUp");
        applyStimulus(8'h75, 0);
        readCol(8'h40, 8'h08, "plain75");
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h75, 0);
        readCol(8'h40, 8'h00, "upReleased");

        bus.row = 8'h01;
        applyStimulus(8'h1C, 1);
        readCol(8'h01, 8'h00, "badParity");
        applyStimulus(8'h1C, 2);
        readCol(8'h01, 8'h00, "badStop");

        sendBits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
        tick(TIMEOUT + 50);
        applyStimulus(8'h1C, 0);
        readCol(8'h01, 8'h02, "afterTimeout");
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h1C, 0);

        glitch(1);
        glitch(FILTER - 1);
        applyStimulus(8'h1C, 0);
        readCol(8'h01, 8'h02, "afterGlitch");
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h1C, 0);

        applyStimulus(8'h07, 0);
        checkOutput("f12Make", 32'(bus.f12), 32'd1);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h07, 0);
        checkOutput("f12Break", 32'(bus.f12), 32'd0);

        applyStimulus(8'h1C, 0);
        sendBits({1'b1, 1'b1, 8'h32, 1'b0}, 4);
        power = 1'b0;
        modelReset();
        tick(3);
        power = 1'b1;
        tick(3);
        readCol(8'h01, 8'h00, "midFrameReset");
        applyStimulus(8'h1C, 0);
        readCol(8'h01, 8'h02, "freshFrame");

        randRows = 1'b1;
        for (int n = 0; n < 100; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 4) begin
                do begin
                    r = $urandom_range(0, 7);
                    c = $urandom_range(0, 7);
                end while (keyCode[r][c] < 0);
                if (keyCode[r][c] >= 256) applyStimulus(8'hE0, 0);
                if ($urandom_range(0, 2) == 0) applyStimulus(8'hF0, 0);
                applyStimulus(8'(keyCode[r][c]), 0);
            end else if (kind == 5) begin
                if ($urandom_range(0, 1) == 0) applyStimulus(8'hF0, 0);
                applyStimulus(8'h07, 0);
            end else if (kind == 7 || kind == 8) begin
                b = 8'($urandom);
                applyStimulus(b, kind - 6);
            end else if (kind == 9) begin
                applyStimulus(($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0, 0);
                b = 8'($urandom);
                applyStimulus(b, 0);
            end else begin
                b = 8'($urandom);
                applyStimulus(b, 0);
            end
        end
        randRows = 1'b0;
        tick(5);
        checkOutput("endCodes", 32'(expCodes.size()), 32'd0);
        checkOutput("endPerr", 32'(expPerr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
